// File: rtl/hdlc_rx_channel.sv
// -----------------------------------------------------------------------------
// hdlc_rx_channel
//
// Serial front end of the HDLC receiver. Watches the raw Rx line for flags
// (0111_1110) and aborts (0111_1111), removes stuffed zeros from the payload,
// packs payload bits LSB-first into bytes and tracks frame boundaries for the
// Rx buffer/controller downstream.
//
// Optional feature macro: RX_IDLE_DETECT_EN
//   defined   : Rx_Idle rises after IDLE_ONES consecutive raw 1s on Rx and
//               clears on the edge a 0 is sampled.
//   undefined : Rx_Idle is tied to 0 and no idle counter is built.
//
// Parameters
//   IDLE_ONES  consecutive raw 1s that mark the line idle (1..255)
//   MAX_BYTES  saturation value of Rx_ByteCount (1..255)
//
// Ports
//   Clk             in   system clock, all logic on posedge
//   Rst             in   asynchronous active-low reset
//   Rx              in   serial line, one bit per Clk
//   RxEN            in   receiver enable; 0 holds the framing FSM in IDLE
//   Rx_FlagDetect   out  1-cycle pulse, flag seen on the raw line
//   Rx_AbortDetect  out  1-cycle pulse, abort seen on the raw line
//   Rx_AbortSignal  out  1-cycle pulse, abort occurred inside a valid frame
//   Rx_ValidFrame   out  high between opening and closing flag
//   Rx_Data         out  assembled byte, bit 0 = first received bit
//   Rx_NewByte      out  1-cycle strobe, Rx_Data valid
//   Rx_EoF          out  1-cycle pulse on closing flag of a non-empty frame
//   Rx_FrameError   out  set with Rx_EoF when a partial byte was pending;
//                        held until the next opening flag
//   Rx_ByteCount    out  bytes in current frame, saturates at MAX_BYTES
//   Rx_Idle         out  line idle indicator
// -----------------------------------------------------------------------------
module hdlc_rx_channel #(
  parameter int unsigned IDLE_ONES = 15,
  parameter int unsigned MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_AbortSignal,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic [7:0] Rx_ByteCount,
  output logic       Rx_Idle
);

  // The first received bit of a pattern ends up in bit 0 of the shift register.
  localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
  localparam logic [7:0] ABORT_PATTERN = 8'hFE;
  localparam logic [7:0] MAX_COUNT     = 8'(MAX_BYTES);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] rx_sr;
  logic [7:0] rx_keep;
  logic       flag_match;
  logic       abort_match;
  logic       out_bit;
  logic       out_keep;
  logic [2:0] ones_cnt;
  logic [6:0] byte_sr;
  logic [2:0] bit_cnt;
  logic       frame_empty;
  logic       frame_open;
  logic       eof_set;
  logic       abort_set;
  logic       data_accept;
  logic       stuffed_zero;

  assign flag_match  = (rx_sr == FLAG_PATTERN);
  assign abort_match = (rx_sr == ABORT_PATTERN);

  // Raw line shift register plus a parallel "keep" mask. When a flag or abort
  // fills the register, all eight of its bits are marked so they are never
  // handed to the payload path as they drain out of bit 0.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rx_sr          <= 8'h00;
      rx_keep        <= 8'h00;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      out_bit        <= 1'b0;
      out_keep       <= 1'b0;
    end else begin
      rx_sr          <= {Rx, rx_sr[7:1]};
      rx_keep        <= (flag_match || abort_match) ? 8'h80 : {1'b1, rx_keep[7:1]};
      Rx_FlagDetect  <= flag_match;
      Rx_AbortDetect <= abort_match;
      out_bit        <= rx_sr[0];
      out_keep       <= rx_keep[0] && !(flag_match || abort_match);
    end
  end

  // A frame with no bytes and no pending bits is treated as flag fill.
  assign frame_empty = (Rx_ByteCount == 8'h00) && (bit_cnt == 3'd0);

  // Framing FSM: state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Framing FSM: next state. RxEN low dominates everything inside a frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (RxEN && Rx_FlagDetect) begin
          state_next = FRAME;
        end
      end
      FRAME: begin
        if (!RxEN) begin
          state_next = IDLE;
        end else if (Rx_AbortDetect) begin
          state_next = IDLE;
        end else if (Rx_FlagDetect && !frame_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Framing FSM: outputs. Pulses are decided here and registered below so
  // EoF/AbortSignal appear the cycle after the detect pulse.
  always_comb begin
    frame_open = 1'b0;
    eof_set    = 1'b0;
    abort_set  = 1'b0;
    case (state)
      IDLE: begin
        frame_open = RxEN && Rx_FlagDetect;
      end
      FRAME: begin
        if (RxEN) begin
          if (Rx_AbortDetect) begin
            abort_set = 1'b1;
          end else if (Rx_FlagDetect && !frame_empty) begin
            eof_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign Rx_ValidFrame = (state == FRAME);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Rx_EoF         <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
    end else begin
      Rx_EoF         <= eof_set;
      Rx_AbortSignal <= abort_set;
      if (frame_open) begin
        Rx_FrameError <= 1'b0;
      end else if (eof_set) begin
        Rx_FrameError <= (bit_cnt != 3'd0);
      end
    end
  end

  // Ones counter runs on the delayed stream; masked flag/abort bits restart it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ones_cnt <= 3'd0;
    end else if (!out_keep || !out_bit) begin
      ones_cnt <= 3'd0;
    end else if (ones_cnt != 3'd6) begin
      ones_cnt <= ones_cnt + 3'd1;
    end
  end

  assign data_accept  = out_keep && (state == FRAME);
  assign stuffed_zero = !out_bit && (ones_cnt == 3'd5);

  // Byte assembly. Leaving FRAME drops any partial byte; opening a frame also
  // restarts the byte count. The completed byte is presented with its strobe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      byte_sr      <= 7'h00;
      bit_cnt      <= 3'd0;
      Rx_Data      <= 8'h00;
      Rx_NewByte   <= 1'b0;
      Rx_ByteCount <= 8'h00;
    end else begin
      Rx_NewByte <= 1'b0;
      if (frame_open) begin
        bit_cnt      <= 3'd0;
        Rx_ByteCount <= 8'h00;
      end else if (state_next != FRAME) begin
        bit_cnt <= 3'd0;
      end else if (data_accept && !stuffed_zero) begin
        byte_sr <= {out_bit, byte_sr[6:1]};
        if (bit_cnt == 3'd7) begin
          Rx_Data    <= {out_bit, byte_sr};
          Rx_NewByte <= 1'b1;
          bit_cnt    <= 3'd0;
          if (Rx_ByteCount < MAX_COUNT) begin
            Rx_ByteCount <= Rx_ByteCount + 8'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

`ifdef RX_IDLE_DETECT_EN
  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_ONES);

  logic [7:0] idle_cnt;

  // Counts raw 1s on the line; saturates so a long idle never wraps.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idle_cnt <= 8'h00;
      Rx_Idle  <= 1'b0;
    end else if (!Rx) begin
      idle_cnt <= 8'h00;
      Rx_Idle  <= 1'b0;
    end else begin
      if (idle_cnt != IDLE_LIMIT) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      if (idle_cnt >= IDLE_LIMIT - 8'd1) begin
        Rx_Idle <= 1'b1;
      end
    end
  end
`else
  assign Rx_Idle = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_channel
//
// Drives flags, stuffed payloads and aborts into hdlc_rx_channel and compares
// the received bytes and framing pulses with what the transmitted frame implies.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_channel;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_AbortSignal;
  logic       Rx_ValidFrame;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic [7:0] Rx_ByteCount;
  logic       Rx_Idle;

  localparam logic [7:0] FLAG  = 8'h7E;
  localparam logic [7:0] ABORT = 8'hFE;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] expBytes[$];
  logic [7:0] gotBytes[$];
  int         eofCount      = 0;
  int         abortSigCount = 0;
  int         abortDetCount = 0;
  logic       lastEofErr    = 1'b0;
  int         txOnes        = 0;
  logic [7:0] pattern;

  hdlc_rx_channel dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .RxEN           (RxEN),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_ByteCount   (Rx_ByteCount),
    .Rx_Idle        (Rx_Idle)
  );

  always #5 Clk = ~Clk;

  // Collects every strobe/pulse once, on the falling edge.
  always @(negedge Clk) begin
    if (Rx_NewByte) gotBytes.push_back(Rx_Data);
    if (Rx_EoF) begin
      eofCount++;
      lastEofErr = Rx_FrameError;
    end
    if (Rx_AbortSignal) abortSigCount++;
    if (Rx_AbortDetect) abortDetCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One line bit per clock, changed on the falling edge.
  task automatic applyStimulus(input logic b);
    @(negedge Clk);
    Rx = b;
  endtask

  task automatic sendRaw(input logic [7:0] p);
    for (int k = 0; k < 8; k++) applyStimulus(p[k]);
  endtask

  // Transmitter-side stuffing: a 0 goes out after every run of five 1s.
  task automatic sendStuffed(input logic b);
    applyStimulus(b);
    if (b) txOnes++;
    else txOnes = 0;
    if (txOnes == 5) begin
      applyStimulus(1'b0);
      txOnes = 0;
    end
  endtask

  task automatic clearMonitor();
    gotBytes.delete();
    eofCount      = 0;
    abortSigCount = 0;
    abortDetCount = 0;
  endtask

  // Sends flag + expBytes + nTrail random bits + flag/abort, then checks the
  // results the frame content implies.
  task automatic runFrame(input int nTrail, input bit isAbort);
    int expCount;
    clearMonitor();
    sendRaw(FLAG);
    txOnes = 0;
    foreach (expBytes[i]) begin
      for (int k = 0; k < 8; k++) sendStuffed(expBytes[i][k]);
    end
    for (int k = 0; k < nTrail; k++) sendStuffed(1'($urandom_range(0, 1)));
    if (isAbort) sendRaw(ABORT);
    else sendRaw(FLAG);
    repeat (6) applyStimulus(1'b0);

    expCount = (expBytes.size() > 128) ? 128 : expBytes.size();
    checkOutput("byteStrobes", gotBytes.size(), expBytes.size());
    for (int i = 0; i < expBytes.size(); i++) begin
      if (i < gotBytes.size()) checkOutput($sformatf("byte%0d", i), gotBytes[i], expBytes[i]);
    end
    checkOutput("validFrameAfter", Rx_ValidFrame, 1'b0);
    if (isAbort) begin
      checkOutput("abortEoF", eofCount, 0);
      checkOutput("abortSignal", abortSigCount, 1);
      checkOutput("abortDetect", abortDetCount, 1);
    end else begin
      checkOutput("eofCount", eofCount, 1);
      checkOutput("eofErr", lastEofErr, nTrail != 0);
      checkOutput("frameErrHeld", Rx_FrameError, nTrail != 0);
      checkOutput("byteCount", Rx_ByteCount, expCount);
      checkOutput("noAbortSignal", abortSigCount, 0);
    end
  endtask

  initial begin
    Rst  = 1'b0;
    Rx   = 1'b0;
    RxEN = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rstFlag", Rx_FlagDetect, 1'b0);
    checkOutput("rstValid", Rx_ValidFrame, 1'b0);
    checkOutput("rstData", Rx_Data, 8'h00);
    checkOutput("rstCount", Rx_ByteCount, 8'h00);
    checkOutput("rstIdle", Rx_Idle, 1'b0);
    Rst  = 1'b1;
    RxEN = 1'b1;

    // Flag latency, then a second flag that must not end the frame.
    pattern = FLAG;
    sendRaw(pattern);
    applyStimulus(pattern[0]);
    checkOutput("flagDetEarly", Rx_FlagDetect, 1'b0);
    applyStimulus(pattern[1]);
    checkOutput("flagDetPulse", Rx_FlagDetect, 1'b1);
    checkOutput("validBeforeFsm", Rx_ValidFrame, 1'b0);
    applyStimulus(pattern[2]);
    checkOutput("flagDetEnd", Rx_FlagDetect, 1'b0);
    checkOutput("validOpen", Rx_ValidFrame, 1'b1);
    for (int k = 3; k < 8; k++) applyStimulus(pattern[k]);

    expBytes = '{8'hA5};
    runFrame(0, 1'b0);
    expBytes = '{8'hFF};
    runFrame(0, 1'b0);
    expBytes = '{8'($urandom), 8'($urandom)};
    runFrame(0, 1'b1);
    expBytes = '{8'h3C};
    runFrame(3, 1'b0);

    // Flag fill keeps the frame open with no EoF; opening clears FrameError.
    clearMonitor();
    sendRaw(FLAG);
    sendRaw(FLAG);
    sendRaw(FLAG);
    checkOutput("fillValid", Rx_ValidFrame, 1'b1);
    checkOutput("fillErrCleared", Rx_FrameError, 1'b0);
    sendRaw(ABORT);
    repeat (6) applyStimulus(1'b0);
    checkOutput("fillEoF", eofCount, 0);
    checkOutput("fillAbort", abortSigCount, 1);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 5);
      expBytes.delete();
      for (int i = 0; i < n; i++) expBytes.push_back(8'($urandom));
      runFrame($urandom_range(0, 7), $urandom_range(0, 3) == 0);
    end

    expBytes.delete();
    for (int i = 0; i < 130; i++) expBytes.push_back(8'($urandom));
    runFrame(0, 1'b0);

    // Dropping RxEN mid-frame ends it silently.
    clearMonitor();
    sendRaw(FLAG);
    txOnes = 0;
    for (int k = 0; k < 12; k++) sendStuffed(1'($urandom_range(0, 1)));
    checkOutput("enValidBefore", Rx_ValidFrame, 1'b1);
    RxEN = 1'b0;
    applyStimulus(1'b0);
    RxEN = 1'b1;
    repeat (6) applyStimulus(1'b0);
    checkOutput("enValidAfter", Rx_ValidFrame, 1'b0);
    checkOutput("enEoF", eofCount, 0);
    checkOutput("enAbort", abortSigCount, 0);

    // Idle line detection.
    clearMonitor();
    repeat (14) applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("idleAfter14", Rx_Idle, 1'b0);
    applyStimulus(1'b0);
`ifdef RX_IDLE_DETECT_EN
    checkOutput("idleAfter15", Rx_Idle, 1'b1);
`else
    checkOutput("idleTied", Rx_Idle, 1'b0);
`endif
    applyStimulus(1'b0);
    checkOutput("idleCleared", Rx_Idle, 1'b0);
    checkOutput("idleNoAbortSig", abortSigCount, 0);

    // Reset in the middle of a frame.
    sendRaw(FLAG);
    txOnes = 0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(1, 255));
      for (int k = 0; k < 8; k++) sendStuffed(b[k]);
    end
    #2 Rst = 1'b0;
    #1;
    checkOutput("midRstValid", Rx_ValidFrame, 1'b0);
    checkOutput("midRstCount", Rx_ByteCount, 8'h00);
    checkOutput("midRstData", Rx_Data, 8'h00);
    checkOutput("midRstNewByte", Rx_NewByte, 1'b0);
    checkOutput("midRstErr", Rx_FrameError, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (4) applyStimulus(1'b0);
    checkOutput("postRstValid", Rx_ValidFrame, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
